// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fb_pkg
// Description : Shared frame-buffer constants, command opcodes and the
//               write-engine state encoding. The HDMI renderer imports the
//               same FB_W/FB_H so both sides agree on the buffer geometry.
// Contents    : FB_W, FB_H, FB_AW, CW, fb_op_e, fb_state_e
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int FB_W  = 90;  // pixels per row
  localparam int FB_H  = 90;  // rows
  localparam int FB_AW = 13;  // write-address width, 2**13 >= 8100
  localparam int CW    = 7;   // coordinate width on the command port

  typedef enum logic [1:0] {
    OP_PIXEL = 2'b00,
    OP_RECT  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } fb_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FILL    = 2'd2
  } fb_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_writer_if.sv
`default_nettype none
// ============================================================================
// Interface   : fb_writer_if
// Description : Drawing-command channel into fb_writer (valid/ready).
// Signals     : I_cmd_valid  command present (master -> slave)
//               O_cmd_ready  engine can accept (slave -> master)
//               I_cmd_op     00 PIXEL, 01 RECT, 10 CLEAR, 11 reserved
//               I_x0/I_y0    start column/row
//               I_x1/I_y1    inclusive end column/row (RECT only)
//               I_colour     palette index to write
// Modports    : master (command source), slave (fb_writer)
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_writer_if;

  logic                  I_cmd_valid;
  logic                  O_cmd_ready;
  logic [1:0]            I_cmd_op;
  logic [fb_pkg::CW-1:0] I_x0;
  logic [fb_pkg::CW-1:0] I_y0;
  logic [fb_pkg::CW-1:0] I_x1;
  logic [fb_pkg::CW-1:0] I_y1;
  logic [1:0]            I_colour;

  modport master (
    output I_cmd_valid, I_cmd_op, I_x0, I_y0, I_x1, I_y1, I_colour,
    input  O_cmd_ready
  );

  modport slave (
    input  I_cmd_valid, I_cmd_op, I_x0, I_y0, I_x1, I_y1, I_colour,
    output O_cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_gen
// Description : Command decode (clamp / reject), x/y scan counters and the
//               row-base accumulator for fb_writer. Addresses are formed as
//               row_base + x; row_base steps by FB_W per row, so no
//               multiplier is needed in the scan loop.
// Ports       : clk_i, rst_ni      clock, async active-low reset
//               load_i             latch decoded bounds, counters to start
//               step_i             advance to the next pixel (row-major)
//               op_i, x0_i..y1_i   raw command fields
//               first_addr_o       address of the first pixel (from inputs)
//               cur_addr_o         address at the current counter position
//               next_addr_o        address of the following pixel
//               last_o             current position is the final pixel
//               reject_o, clip_o   command rejected / end point clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_gen #(
  parameter int FB_W = 90,
  parameter int FB_H = 90,
  parameter int AW   = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [1:0]            op_i,
  input  logic [fb_pkg::CW-1:0] x0_i,
  input  logic [fb_pkg::CW-1:0] y0_i,
  input  logic [fb_pkg::CW-1:0] x1_i,
  input  logic [fb_pkg::CW-1:0] y1_i,
  output logic [AW-1:0]         first_addr_o,
  output logic [AW-1:0]         cur_addr_o,
  output logic [AW-1:0]         next_addr_o,
  output logic                  last_o,
  output logic                  reject_o,
  output logic                  clip_o
);

  import fb_pkg::*;

  localparam logic [CW-1:0] c_XMAX = CW'(FB_W - 1);
  localparam logic [CW-1:0] c_YMAX = CW'(FB_H - 1);
  localparam logic [AW-1:0] c_ROW  = AW'(FB_W);

  logic [CW-1:0] xs_d, xe_d, ys_d, ye_d;
  logic [AW-1:0] row_d;
  logic [CW-1:0] x_q, y_q, xs_q, xe_q, ye_q;
  logic [AW-1:0] row_q;
  logic          w_eol;

  // Decode the command into an inclusive scan window.
  always_comb begin
    xs_d     = x0_i;
    xe_d     = x0_i;
    ys_d     = y0_i;
    ye_d     = y0_i;
    reject_o = 1'b0;
    clip_o   = 1'b0;
    case (op_i)
      OP_PIXEL: begin
        reject_o = (x0_i > c_XMAX) || (y0_i > c_YMAX);
      end
      OP_RECT: begin
        xe_d     = (x1_i > c_XMAX) ? c_XMAX : x1_i;
        ye_d     = (y1_i > c_YMAX) ? c_YMAX : y1_i;
        clip_o   = (x1_i > c_XMAX) || (y1_i > c_YMAX);
        reject_o = (x0_i > c_XMAX) || (y0_i > c_YMAX) ||
                   (x0_i > xe_d)   || (y0_i > ye_d);
      end
      OP_CLEAR: begin
        xs_d = '0;
        xe_d = c_XMAX;
        ys_d = '0;
        ye_d = c_YMAX;
      end
      default: reject_o = 1'b1;
    endcase
  end

  // Start-row base FB_W*ys built as a constant shift-and-add; only used
  // once per command, the scan itself just adds FB_W per row.
  always_comb begin
    row_d = '0;
    for (int i = 0; i < AW; i++) begin
      if (c_ROW[i]) row_d = row_d + (AW'(ys_d) << i);
    end
  end

  assign first_addr_o = row_d + AW'(xs_d);
  assign cur_addr_o   = row_q + AW'(x_q);
  assign w_eol        = (x_q == xe_q);
  assign last_o       = w_eol && (y_q == ye_q);
  assign next_addr_o  = w_eol ? (row_q + c_ROW + AW'(xs_q)) : (cur_addr_o + AW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      xs_q  <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      row_q <= '0;
    end else if (load_i) begin
      x_q   <= xs_d;
      y_q   <= ys_d;
      xs_q  <= xs_d;
      xe_q  <= xe_d;
      ye_q  <= ye_d;
      row_q <= row_d;
    end else if (step_i) begin
      if (w_eol) begin
        x_q   <= xs_q;
        y_q   <= y_q + CW'(1);
        row_q <= row_q + c_ROW;
      end else begin
        x_q <= x_q + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_writer
// Description : Write-side engine for the 90x90 2bpp frame buffer. Turns
//               PIXEL / RECT / CLEAR commands into one registered write per
//               cycle, row-major, on the buffer's second RAM port.
// Ports       : I_pxl_clk   pixel clock
//               I_rst_n     asynchronous active-low reset
//               cmd         fb_writer_if.slave command channel
//               I_vs        vertical sync (active high)
//               O_wr_en     buffer write strobe
//               O_wr_addr   write address = FB_W*y + x
//               O_wr_data   write data (palette index)
//               O_busy      command in progress
//               O_cmd_err   one-cycle pulse on a rejected or clipped command
// Options     : FB_WRITER_VSYNC_GATE_EN - RECT/CLEAR wait in WAIT_VS for a
//               rising edge of I_vs before filling; otherwise I_vs is unused.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_writer #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int AW   = fb_pkg::FB_AW
) (
  input  logic            I_pxl_clk,
  input  logic            I_rst_n,
  fb_writer_if.slave      cmd,
  input  logic            I_vs,
  output logic            O_wr_en,
  output logic [AW-1:0]   O_wr_addr,
  output logic [1:0]      O_wr_data,
  output logic            O_busy,
  output logic            O_cmd_err
);

  import fb_pkg::*;

  fb_state_e     state_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [1:0]    wr_data_q;
  logic [1:0]    colour_q;
  logic          err_q;
  logic          reject_q;   // FILL is a one-cycle no-write pass for a rejected command

  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic          w_reject;
  logic          w_clip;
  logic [AW-1:0] w_first_addr;
  logic [AW-1:0] w_cur_addr;
  logic [AW-1:0] w_next_addr;

  assign w_accept = cmd.I_cmd_valid && (state_q == IDLE);
  assign w_step   = (state_q == FILL) && !reject_q && !w_last;

  fb_addr_gen #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .AW   (AW)
  ) u_addr_gen (
    .clk_i        (I_pxl_clk),
    .rst_ni       (I_rst_n),
    .load_i       (w_accept),
    .step_i       (w_step),
    .op_i         (cmd.I_cmd_op),
    .x0_i         (cmd.I_x0),
    .y0_i         (cmd.I_y0),
    .x1_i         (cmd.I_x1),
    .y1_i         (cmd.I_y1),
    .first_addr_o (w_first_addr),
    .cur_addr_o   (w_cur_addr),
    .next_addr_o  (w_next_addr),
    .last_o       (w_last),
    .reject_o     (w_reject),
    .clip_o       (w_clip)
  );

`ifdef FB_WRITER_VSYNC_GATE_EN
  logic vs_q;
  logic w_vs_rise;
  assign w_vs_rise = I_vs && !vs_q;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) vs_q <= 1'b0;
    else          vs_q <= I_vs;
  end
`else
  logic w_vs_unused;
  assign w_vs_unused = I_vs;
`endif

  // The write bus always shows the pixel at the addr-gen counter position,
  // so the first write is registered straight from the decoded command at
  // acceptance and later ones from next_addr.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      colour_q  <= '0;
      err_q     <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            colour_q <= cmd.I_colour;
            reject_q <= w_reject;
            err_q    <= w_reject || w_clip;
            if (w_reject) begin
              state_q <= FILL;
`ifdef FB_WRITER_VSYNC_GATE_EN
            end else if ((cmd.I_cmd_op == OP_RECT) || (cmd.I_cmd_op == OP_CLEAR)) begin
              state_q <= WAIT_VS;
`endif
            end else begin
              state_q   <= FILL;
              wr_en_q   <= 1'b1;
              wr_addr_q <= w_first_addr;
              wr_data_q <= cmd.I_colour;
            end
          end
        end
`ifdef FB_WRITER_VSYNC_GATE_EN
        WAIT_VS: begin
          if (w_vs_rise) begin
            state_q   <= FILL;
            wr_en_q   <= 1'b1;
            wr_addr_q <= w_cur_addr;
            wr_data_q <= colour_q;
          end
        end
`endif
        FILL: begin
          if (reject_q || w_last) begin
            state_q <= IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= w_next_addr;
            wr_data_q <= colour_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef FB_WRITER_VSYNC_GATE_EN
  logic [AW-1:0] w_cur_addr_unused;
  assign w_cur_addr_unused = w_cur_addr;
`endif

  assign cmd.O_cmd_ready = (state_q == IDLE);
  assign O_busy          = (state_q != IDLE);
  assign O_wr_en         = wr_en_q;
  assign O_wr_addr       = wr_addr_q;
  assign O_wr_data       = wr_data_q;
  assign O_cmd_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_writer
// Description : Self-checking bench for fb_writer. A reference model pushes
//               the expected write stream into a scoreboard when a command
//               is driven; every observed write is popped and compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs    = 1'b0;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        cmd_err;

  int n_vec = 0;
  int n_err = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int cyc = 0, wr_cnt = 0, busy_cnt = 0, err_cnt = 0;
  int first_wr = -1, last_wr = -1, last_addr = -1;

  fb_writer_if bus ();

  fb_writer dut (
    .I_pxl_clk (clk),
    .I_rst_n   (rst_n),
    .cmd       (bus),
    .I_vs      (vs),
    .O_wr_en   (wr_en),
    .O_wr_addr (wr_addr),
    .O_wr_data (wr_data),
    .O_busy    (busy),
    .O_cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score any write.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = int'(wr_addr);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      check("wr_expected", exp_addr_q.size() > 0, 1);
      if (exp_addr_q.size() > 0) begin
        check("wr_addr", wr_addr, exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_data_q.pop_front());
      end
    end
    if (cmd_err === 1'b1) err_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  // Reference model: push expected writes; return count and error flag.
  task automatic model(input int op, input int x0, input int y0, input int x1,
                       input int y1, input int col, output int n, output bit err);
    int xs, xe, ys, ye;
    bit rej;
    n = 0; err = 0; rej = 0;
    xs = x0; xe = x0; ys = y0; ye = y0;
    case (op)
      0: rej = (x0 >= 90) || (y0 >= 90);
      1: begin
        xe  = (x1 > 89) ? 89 : x1;
        ye  = (y1 > 89) ? 89 : y1;
        err = (x1 > 89) || (y1 > 89);
        rej = (x0 >= 90) || (y0 >= 90) || (x0 > xe) || (y0 > ye);
      end
      2: begin xs = 0; xe = 89; ys = 0; ye = 89; end
      default: rej = 1;
    endcase
    if (rej) err = 1;
    else begin
      for (int y = ys; y <= ye; y++) begin
        for (int x = xs; x <= xe; x++) begin
          exp_addr_q.push_back(90 * y + x);
          exp_data_q.push_back(col);
          n++;
        end
      end
    end
  endtask

  // Present a command, take it through acceptance (and the vsync wait when
  // the gate is built in). Returns model results and whether it was gated.
  task automatic issue(input int op, input int x0, input int y0, input int x1,
                       input int y1, input int col, output int n, output bit err,
                       output bit gated);
    int guard;
    model(op, x0, y0, x1, y1, col, n, err);
    guard = 0;
    while (bus.O_cmd_ready !== 1'b1 && guard < 20) begin tick(); guard++; end
    check("ready_before_cmd", bus.O_cmd_ready, 1);
    wr_cnt = 0; busy_cnt = 0; err_cnt = 0; first_wr = -1; last_wr = -1;
    bus.I_cmd_op = 2'(op);
    bus.I_x0 = 7'(x0); bus.I_y0 = 7'(y0);
    bus.I_x1 = 7'(x1); bus.I_y1 = 7'(y1);
    bus.I_colour = 2'(col);
    bus.I_cmd_valid = 1'b1;
    tick();
    bus.I_cmd_valid = 1'b0;
    check("err_at_accept", cmd_err, err);
    gated = 0;
`ifdef FB_WRITER_VSYNC_GATE_EN
    gated = ((op == 1) || (op == 2)) && (n > 0);
    if (gated) begin
      check("gate_hold", wr_en, 0);
      repeat (3) tick();
      vs = 1'b1;
      tick();
      vs = 1'b0;
    end
`endif
    check("first_wr", wr_en, n > 0);
  endtask

  task automatic send(input int op, input int x0, input int y0, input int x1,
                      input int y1, input int col, input int spam);
    int n, guard;
    bit err, gated;
    issue(op, x0, y0, x1, y1, col, n, err, gated);
    // Offer another command while busy; it must be ignored.
    repeat (spam) begin
      bus.I_cmd_op = 2'b00; bus.I_x0 = 7'd0; bus.I_y0 = 7'd0; bus.I_colour = 2'd2;
      bus.I_cmd_valid = 1'b1;
      tick();
      check("ready_while_busy", bus.O_cmd_ready, 0);
    end
    bus.I_cmd_valid = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 9000) begin tick(); guard++; end
    check("done_in_budget", guard < 9000, 1);
    check("busy_cycles", busy_cnt, ((n > 0) ? n : 1) + (gated ? 4 : 0));
    check("wr_count", wr_cnt, n);
    if (n > 0) check("wr_contiguous", last_wr - first_wr + 1, n);
    check("err_pulses", err_cnt, err);
    check("ready_after", bus.O_cmd_ready, 1);
    check("sb_empty", exp_addr_q.size(), 0);
  endtask

  initial begin
    int n, guard;
    bit err, gated;
    bus.I_cmd_valid = 1'b0; bus.I_cmd_op = 2'b00;
    bus.I_x0 = '0; bus.I_y0 = '0; bus.I_x1 = '0; bus.I_y1 = '0; bus.I_colour = '0;

    repeat (3) tick();
    check("rst_ready", bus.O_cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_err", cmd_err, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    send(0, 5, 2, 0, 0, 3, 0);        // pixel -> 185
    send(1, 10, 10, 12, 11, 1, 3);    // 6 writes, busy-time command ignored
    send(2, 0, 0, 0, 0, 0, 0);        // clear 0..8099
    check("clear_last_addr", last_addr, 8099);
    send(1, 88, 0, 120, 1, 2, 0);     // clamped x1 -> 88,89,178,179
    send(0, 95, 3, 0, 0, 1, 0);       // pixel out of range
    send(3, 1, 1, 1, 1, 1, 0);        // reserved op
    send(1, 20, 5, 10, 8, 3, 0);      // x0 > x1
    send(1, 0, 88, 1, 99, 1, 0);      // clamped y1
    send(1, 89, 89, 89, 89, 2, 0);    // corner pixel via RECT
    check("corner_addr", last_addr, 8099);

    // Reset in the middle of a CLEAR, right after write 40.
    issue(2, 0, 0, 0, 0, 1, n, err, gated);
    guard = 0;
    while (wr_cnt < 40 && guard < 200) begin tick(); guard++; end
    check("wr40_reached", wr_cnt, 40);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.O_cmd_ready, 1);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.O_cmd_ready, 1);
    check("post_rst_wr_en", wr_en, 0);

    send(0, 0, 0, 0, 0, 2, 0);        // engine usable after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
